// File: rtl/chgrp_accum_ctrl.sv
// chgrp_accum_ctrl
// Channel-group accumulation controller. For each output tile it sums
// cfg_num_grp input beats lane-wise with saturation, presents the tile sums
// on a valid/ready output port, and repeats for cfg_num_tile tiles. A
// one-cycle done pulse marks the end of a job.
//
// Ports
//   clk, rst           clock (rising edge) and synchronous active-low reset
//   start, abort       begin a job (IDLE only) / cancel the current job
//   cfg_num_grp        beats summed per tile (0 behaves as 1)
//   cfg_num_tile       tiles per job (0 behaves as 1)
//   in_valid/in_ready  input beat handshake; in_data holds LANES signed IW-bit lanes
//   out_valid/out_ready output tile handshake; out_data holds LANES signed AW-bit sums
//   busy               high whenever a job is in progress
//   done               one-cycle pulse after the last tile is accepted
module chgrp_accum_ctrl #(
    parameter int LANES = 16,
    parameter int IW    = 11,
    parameter int AW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            cfg_num_grp,
    input  logic [7:0]            cfg_num_tile,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*AW-1:0]   out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Signed saturating add of a sign-extended IW-bit lane to an AW-bit sum.
    // One guard bit is enough: overflow shows as the two top bits differing.
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [IW-1:0] b);
        logic [AW:0] sum;
        sum = {a[AW-1], a} + {{(AW+1-IW){b[IW-1]}}, b};
        if (sum[AW] != sum[AW-1]) begin
            sat_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            sat_add = sum[AW-1:0];
        end
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [7:0]            num_grp_r;
    logic [7:0]            num_tile_r;
    logic [7:0]            grp_cnt_r;
    logic [7:0]            tile_cnt_r;
    logic [AW-1:0]         acc_r [LANES];
    logic [AW-1:0]         acc_nxt_s [LANES];
    logic [LANES*AW-1:0]   out_data_r;
    logic                  done_r;
    logic                  xfer_s;
    logic                  last_grp_s;
    logic                  last_tile_s;

    assign xfer_s      = in_valid && (state_r == ST_ACC) && !abort;
    assign last_grp_s  = ((grp_cnt_r + 8'd1) == num_grp_r);
    assign last_tile_s = ((tile_cnt_r + 8'd1) == num_tile_r);

    // Per-lane next sum; the first beat of a tile ignores the old contents.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            acc_nxt_s[k] = sat_add((grp_cnt_r == 8'd0) ? {AW{1'b0}} : acc_r[k],
                                   in_data[k*IW +: IW]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = start ? ST_ACC : ST_IDLE;
                ST_ACC:  state_nxt_s = (xfer_s && last_grp_s) ? ST_OUT : ST_ACC;
                ST_OUT: begin
                    if (out_ready) begin
                        state_nxt_s = last_tile_s ? ST_IDLE : ST_ACC;
                    end else begin
                        state_nxt_s = ST_OUT;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Configuration, counters, accumulators, output register and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            num_grp_r  <= 8'd0;
            num_tile_r <= 8'd0;
            grp_cnt_r  <= 8'd0;
            tile_cnt_r <= 8'd0;
            for (int k = 0; k < LANES; k++) begin
                acc_r[k] <= {AW{1'b0}};
            end
            out_data_r <= {(LANES*AW){1'b0}};
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort) begin
                grp_cnt_r  <= 8'd0;
                tile_cnt_r <= 8'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            num_grp_r  <= (cfg_num_grp == 8'd0) ? 8'd1 : cfg_num_grp;
                            num_tile_r <= (cfg_num_tile == 8'd0) ? 8'd1 : cfg_num_tile;
                            grp_cnt_r  <= 8'd0;
                            tile_cnt_r <= 8'd0;
                            for (int k = 0; k < LANES; k++) begin
                                acc_r[k] <= {AW{1'b0}};
                            end
                        end
                    end
                    ST_ACC: begin
                        if (xfer_s) begin
                            grp_cnt_r <= grp_cnt_r + 8'd1;
                            for (int k = 0; k < LANES; k++) begin
                                acc_r[k] <= acc_nxt_s[k];
                            end
                            if (last_grp_s) begin
                                for (int k = 0; k < LANES; k++) begin
                                    out_data_r[k*AW +: AW] <= acc_nxt_s[k];
                                end
                            end
                        end
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            grp_cnt_r <= 8'd0;
                            if (last_tile_s) begin
                                tile_cnt_r <= 8'd0;
                                done_r     <= 1'b1;
                            end else begin
                                tile_cnt_r <= tile_cnt_r + 8'd1;
                            end
                        end
                    end
                    default: begin
                        grp_cnt_r  <= 8'd0;
                        tile_cnt_r <= 8'd0;
                    end
                endcase
            end
        end
    end

    // Output decode from the state register and the output registers.
    always_comb begin
        in_ready  = (state_r == ST_ACC);
        out_valid = (state_r == ST_OUT);
        busy      = (state_r != ST_IDLE);
        done      = done_r;
        out_data  = out_data_r;
    end

endmodule

// File: tb/tb_chgrp_accum_ctrl.sv
// Testbench for chgrp_accum_ctrl: directed jobs plus a transaction-level
// model (job active / tile pending / running lane sums) checked every cycle.
`timescale 1ns/1ps
module tb_chgrp_accum_ctrl;
    localparam int LANES = 16;
    localparam int IW    = 11;
    localparam int AW    = 16;
    localparam int SMAX  = 32767;
    localparam int SMIN  = -32768;

    logic                clk = 1'b0;
    logic                rst, start, abort;
    logic [7:0]          cfg_num_grp, cfg_num_tile;
    logic                in_valid, in_ready;
    logic [LANES*IW-1:0] in_data;
    logic                out_valid, out_ready;
    logic [LANES*AW-1:0] out_data;
    logic                busy, done;

    int checks = 0;
    int errors = 0;

    // Model state: values the DUT outputs must show after the last edge.
    logic                mon_en = 1'b0;
    logic                m_active = 1'b0, m_pending = 1'b0, m_done = 1'b0;
    int                  m_beats = 0, m_tiles = 0, m_g = 1, m_t = 1;
    int                  m_acc [LANES];
    logic [LANES*AW-1:0] m_out = '0;
    int                  out_cnt = 0, done_cnt = 0;
    logic [LANES*AW-1:0] last_out = '0;

    always #5 clk = ~clk;

    chgrp_accum_ctrl #(.LANES(LANES), .IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_num_grp(cfg_num_grp), .cfg_num_tile(cfg_num_tile),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [LANES*AW-1:0] act, input logic [LANES*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*IW-1:0] gen_beat(input int mode, input int idx);
        logic [LANES*IW-1:0] v;
        int x;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                0:       x = idx + 1;
                1:       x = (k == 0) ? 1023 : (k == 1) ? -1024 : (idx * 7 - k * 3);
                2:       x = (k == 0) ? 1023 : (k == 1) ? -1024 : (k * 61 - idx * 97);
                default: x = k * 37 - idx * 113 + 5;
            endcase
            v[k*IW +: IW] = x[IW-1:0];
        end
        return v;
    endfunction

    // Compare DUT against the model, then advance the model over the next edge.
    always @(negedge clk) begin
        int lv, s;
        if (mon_en) begin
            check("out_valid", out_valid, m_pending);
            check("in_ready", in_ready, m_active && !m_pending);
            check("busy", busy, m_active);
            check("done", done, m_done);
            if (m_pending) check("out_data", out_data, m_out);
            if (out_valid && out_ready) begin
                out_cnt++;
                last_out = out_data;
            end
            if (done === 1'b1) done_cnt++;
        end
        m_done = 1'b0;
        if (rst !== 1'b1) begin
            m_active = 1'b0; m_pending = 1'b0; m_beats = 0;
        end else if (abort) begin
            m_active = 1'b0; m_pending = 1'b0; m_beats = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_g = (cfg_num_grp == 8'd0) ? 1 : int'(cfg_num_grp);
                m_t = (cfg_num_tile == 8'd0) ? 1 : int'(cfg_num_tile);
                m_beats = 0; m_tiles = 0;
            end
        end else if (m_pending) begin
            if (out_ready) begin
                m_pending = 1'b0;
                m_tiles++;
                if (m_tiles == m_t) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
                lv = $signed(in_data[k*IW +: IW]);
                s = ((m_beats == 0) ? 0 : m_acc[k]) + lv;
                if (s > SMAX) s = SMAX;
                if (s < SMIN) s = SMIN;
                m_acc[k] = s;
            end
            m_beats++;
            if (m_beats == m_g) begin
                for (int k = 0; k < LANES; k++) m_out[k*AW +: AW] = m_acc[k][AW-1:0];
                m_pending = 1'b1;
                m_beats = 0;
            end
        end
    end

    // Run one job; stall_tile < 0 disables stalling, abort_after = 0 disables abort.
    task automatic run_job(input int grp, input int tile, input int mode,
                           input int stall_tile, input int stall_cycles, input int abort_after);
        int idx = 0, tidx = 0, stall_left = stall_cycles, cyc = 0;
        logic xfer, ohs, fin;
        cfg_num_grp = grp[7:0];
        cfg_num_tile = tile[7:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_num_grp = 8'hFF;
        cfg_num_tile = 8'hFF;
        fin = 1'b0;
        while (!fin) begin
            in_valid  = 1'b1;
            in_data   = gen_beat(mode, idx);
            out_ready = !(tidx == stall_tile && stall_left > 0);
            abort     = (abort_after > 0 && idx == abort_after);
            start     = (idx == 1 && grp > 1);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stall_left--;
                check("stall_in_ready", in_ready, 1'b0);
            end
            xfer = in_valid && in_ready;
            ohs  = out_valid && out_ready;
            if (abort || done) fin = 1'b1;
            cyc++;
            if (cyc > 2000) begin
                checks++; errors++;
                $display("FAIL job_timeout: no done after %0d cycles, required done", cyc);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            if (xfer) idx++;
            if (ohs) tidx++;
        end
        in_valid = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b0; start = 1'b1; abort = 1'b0; cfg_num_grp = 8'd3; cfg_num_tile = 8'd2;
        in_valid = 1'b1; in_data = gen_beat(0, 0); out_ready = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Test 1: grp=4, beats of +1..+4 on every lane.
        out_cnt = 0; done_cnt = 0;
        run_job(4, 1, 0, -1, 0, 0);
        check("t1_sum", last_out, {LANES{16'd10}});
        check("t1_outs", out_cnt, 1);
        check("t1_done", done_cnt, 1);

        // Test 2: large lanes without saturation.
        out_cnt = 0; done_cnt = 0;
        run_job(4, 1, 1, -1, 0, 0);
        check("t2_lane0", last_out[15:0], 16'd4092);
        check("t2_lane1", last_out[31:16], 16'hF000);

        // Test 3: grp=40 drives lane0 to +max and lane1 to -max.
        out_cnt = 0; done_cnt = 0;
        run_job(40, 1, 2, -1, 0, 0);
        check("t3_lane0_sat", last_out[15:0], 16'h7FFF);
        check("t3_lane1_sat", last_out[31:16], 16'h8000);

        // Test 4: three tiles, second tile stalled for 5 cycles.
        out_cnt = 0; done_cnt = 0;
        run_job(2, 3, 3, 1, 5, 0);
        check("t4_outs", out_cnt, 3);
        check("t4_done", done_cnt, 1);

        // Test 5: abort after the 2nd beat, then a clean job.
        out_cnt = 0; done_cnt = 0;
        run_job(4, 1, 0, -1, 0, 2);
        check("t5_busy", busy, 1'b0);
        check("t5_out_valid", out_valid, 1'b0);
        repeat (5) @(posedge clk); #1;
        check("t5_outs", out_cnt, 0);
        check("t5_done", done_cnt, 0);
        run_job(4, 1, 0, -1, 0, 0);
        check("t5_rerun_sum", last_out, {LANES{16'd10}});
        check("t5_rerun_done", done_cnt, 1);

        // Test 6: zero config behaves as one group, one tile.
        out_cnt = 0; done_cnt = 0;
        run_job(0, 0, 3, -1, 0, 0);
        check("t6_outs", out_cnt, 1);
        check("t6_done", done_cnt, 1);
        check("t6_lane0", last_out[15:0], 16'd5);
        check("t6_lane3", last_out[63:48], 16'd116);

        // Test 6b: reset while an output is waiting.
        out_cnt = 0; done_cnt = 0;
        cfg_num_grp = 8'd0; cfg_num_tile = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = gen_beat(3, 0); out_ready = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            checks++; errors++;
            $display("FAIL t6_wait_out: out_valid low after %0d cycles, required high", w);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_out_valid", out_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_out_data", out_data, '0);
        rst = 1'b1; in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("t6_rst_no_done", done_cnt, 0);
        check("t6_rst_no_out", out_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/chgrp_accum_ctrl.md
CHGRP_ACCUM_CTRL -- requirements
Module: chgrp_accum_ctrl

Interface
REQ-001 Parameter LANES, default 16: lanes per beat.
REQ-002 Parameter IW, default 11: signed width of each input lane.
REQ-003 Parameter AW, default 16: signed width of each accumulator and output lane.
REQ-004 Port clk, input, 1: clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-low.
REQ-006 Port start, input, 1: begin a job; sampled only in IDLE.
REQ-007 Port abort, input, 1: synchronous job cancel.
REQ-008 Port cfg_num_grp, input, 8: input-channel groups summed per output tile; 0 is treated as 1.
REQ-009 Port cfg_num_tile, input, 8: output tiles per job; 0 is treated as 1.
REQ-010 Port in_valid, input, 1: in_data valid.
REQ-011 Port in_ready, output, 1: controller accepts in_data.
REQ-012 Port in_data, input, LANES*IW: packed signed lanes; lane k is bits [k*IW +: IW].
REQ-013 Port out_valid, output, 1: out_data valid.
REQ-014 Port out_ready, input, 1: downstream accepts out_data.
REQ-015 Port out_data, output, LANES*AW: packed signed accumulated lanes.
REQ-016 Port busy, output, 1: high in every state except IDLE.
REQ-017 Port done, output, 1: one-cycle pulse when a job completes.

Function
REQ-018 The FSM has three states: IDLE, ACC and OUT.
REQ-019 IDLE with start=1:
  - latch cfg_num_grp and cfg_num_tile, applying the 0->1 mapping;
  - clear the group and tile counters and all accumulators;
  - move to ACC on the next cycle.
REQ-020 Config inputs are ignored outside the IDLE start cycle; start is ignored while busy.
REQ-021 in_ready=1 only in ACC; a beat transfers when in_valid and in_ready are both high.
REQ-022 On each transfer, every lane is updated as acc[k] <= sat_AW(acc[k] + sext(in_data lane k)).
  - sat_AW clamps to +32767 / -32768 when AW=16.
REQ-023 The first transfer of a tile loads sext(lane) into the accumulator; earlier accumulator contents are ignored.
REQ-024 After a transfer, the group counter increments.
  - On the transfer that reaches the latched group count, out_data is registered with the final sums and the FSM moves to OUT.
  - out_valid rises the cycle after that last transfer (latency 1).
REQ-025 In OUT: out_valid=1, and out_data stays stable until out_ready=1.
REQ-026 OUT with out_ready=1, more tiles remaining:
  - increment the tile counter and clear the group counter;
  - return to ACC the next cycle.
REQ-027 OUT with out_ready=1, last tile: go to IDLE and pulse done=1 for one cycle.
REQ-028 A beat offered while not in ACC is not consumed; in_valid may stay high.
REQ-029 abort=1 in any state:
  - go to IDLE next cycle and clear the counters and out_valid;
  - done is not asserted;
  - abort has priority over a simultaneous transfer, output handshake or start.
REQ-030 With cfg_num_grp=1, each tile is exactly one beat, and the ACC->OUT->ACC cycle repeats with no beat lost.

Reset
REQ-031 While rst=0 on a clock edge, all of the following hold:
  - state=IDLE;
  - counters=0 and accumulators=0;
  - out_data=0;
  - out_valid=0, in_ready=0, busy=0, done=0.
REQ-032 Reset mid-job discards all partial sums; no output or done follows.

Verification
REQ-033 Test 1: grp=4, tile=1; all lanes=+1, then +2, +3, +4, in_valid continuous.
  - Required: every out_data lane=10, one cycle after the 4th beat, then a done pulse after out_ready.
REQ-034 Test 2: grp=4; lane0 carries +1023 on every beat (4092), lane1 carries -1024 on every beat (-4096).
  - Required: no saturation; exact sign-extended sums.
REQ-035 Test 3: grp=40; lane0=+1023 on every beat.
  - Required: lane0 clamps at 32767 and holds.
REQ-036 Test 4: grp=2, tile=3; out_ready held low for 5 cycles on tile 2.
  - Required: out_data stable and in_ready=0 while stalled.
  - Required: 3 outputs in total, then done.
REQ-037 Test 5: abort asserted after the 2nd beat of grp=4.
  - Required: IDLE next cycle, busy=0, no out_valid, no done.
  - Required: a following start runs cleanly from zero.
REQ-038 Test 6: cfg_num_grp=0 and cfg_num_tile=0.
  - Required: behaves as 1 and 1, one beat in, one output, done.
  - Required: rst pulsed mid-OUT clears out_valid on the next edge.
